// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - shared loader state encodings and stream constants
package imem_program_loader_pkg;

    localparam int LD_DATA_W            = 32;
    localparam int LD_BYTES_PER_WORD    = 4;
    localparam int LD_DEFAULT_ADDR_W    = 12;
    localparam int LD_DEFAULT_MAX_WORDS = 4096;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_WORD,
        LD_WRITE,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } ld_state_e;

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// rtl/imem_program_loader_word_assembler.sv - MSB-first byte shift register with word_full flag
module imem_program_loader_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 accept_i,
    input  logic [7:0]           byte_i,
    output logic [LD_DATA_W-1:0] word_o,
    output logic                 word_full_o
);

    logic [LD_DATA_W-1:0] word_q, word_d;
    logic [1:0]           cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            word_d = {word_q[LD_DATA_W-9:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // High in the cycle whose accepted byte completes the word.
    assign word_o      = word_q;
    assign word_full_o = accept_i && (cnt_q == 2'(LD_BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - boot byte-stream loader into imem, holds CPU until image done; LOADER_CHECKSUM_EN adds a trailing XOR byte
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W    = LD_DEFAULT_ADDR_W,
    parameter int MAX_WORDS = LD_DEFAULT_MAX_WORDS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic                 imem_we_o,
    output logic [ADDR_W-1:0]    imem_addr_o,
    output logic [LD_DATA_W-1:0] imem_wdata_o,
    output logic                 cpu_hold_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

    ld_state_e       state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [ADDR_W:0] n_q, n_d, k_q, k_d, k_inc;
    logic [15:0]     n_full;
    logic            accept, clear, word_full;
    logic [LD_DATA_W-1:0] word;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_e AFTER_LAST = LD_CHECK;
    logic [7:0] csum_q, csum_d;
`else
    localparam ld_state_e AFTER_LAST = LD_DONE;
`endif

    // Status and handshake depend on state only, so ready never follows valid.
    assign byte_ready_o = state_q inside {LD_LEN_HI, LD_LEN_LO, LD_WORD, LD_CHECK};
    assign busy_o       = state_q inside {LD_LEN_HI, LD_LEN_LO, LD_WORD, LD_WRITE, LD_CHECK};
    assign done_o       = (state_q == LD_DONE);
    assign error_o      = (state_q == LD_ERROR);
    assign cpu_hold_o   = (state_q != LD_DONE);
    assign imem_we_o    = (state_q == LD_WRITE);
    assign imem_addr_o  = k_q[ADDR_W-1:0];
    assign imem_wdata_o = word;

    assign accept = byte_valid_i && byte_ready_o;
    assign clear  = start_i && (state_q inside {LD_IDLE, LD_DONE, LD_ERROR});
    assign n_full = {hi_q, byte_i};
    assign k_inc  = k_q + 1'b1;

    imem_program_loader_word_assembler u_asm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear),
        .accept_i   (accept && (state_q == LD_WORD)),
        .byte_i     (byte_i),
        .word_o     (word),
        .word_full_o(word_full)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        n_d     = n_q;
        k_d     = k_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start_i) begin
                    state_d = LD_LEN_HI;
                    k_d     = '0;
                end
            end
            LD_LEN_HI: begin
                if (accept) begin
                    hi_d    = byte_i;
                    state_d = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (accept) begin
                    n_d = n_full[ADDR_W:0];
                    if (n_full == '0)                  state_d = AFTER_LAST;
                    else if ({1'b0, n_full} > MAX_W17) state_d = LD_ERROR;
                    else                               state_d = LD_WORD;
                end
            end
            LD_WORD: begin
                if (word_full) state_d = LD_WRITE;
            end
            LD_WRITE: begin
                k_d     = k_inc;
                state_d = (k_inc == n_q) ? AFTER_LAST : LD_WORD;
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (accept) state_d = (byte_i == csum_q) ? LD_DONE : LD_ERROR;
            end
`endif
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= LD_IDLE;
            hi_q    <= '0;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every stream byte except the checksum byte itself.
    always_comb begin
        csum_d = csum_q;
        if (clear)                                 csum_d = '0;
        else if (accept && (state_q != LD_CHECK)) csum_d = csum_q ^ byte_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, imem_we, cpu_hold, busy, done, error;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cyc = -1;
    int last_acc = -1;
    int ready_in_write = 0;
    logic done_prev = 1'b0;
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [7:0]  s[$];

    imem_program_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .byte_i      (byte_in),
        .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .cpu_hold_o  (cpu_hold),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
            if (byte_ready) ready_in_write++;
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
        ready_in_write = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input string tag, input bit rnd, input bit add_sum);
        int i = 0;
        int budget = 0;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        if (add_sum) begin
            foreach (s[j]) x ^= s[j];
            s.push_back(x);
        end
`else
        if (add_sum) i = 0;
`endif
        while (i < s.size() && budget < 1000) begin
            byte_in    = s[i];
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid && byte_ready) begin
                last_acc = cyc;
                i++;
            end
            @(negedge clk);
            budget++;
        end
        byte_valid = 1'b0;
        chk({tag, "_bytes_sent"}, 64'(i), 64'(s.size()));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(byte_ready), 64'd0);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd1);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Two-word load with valid held high
        clear_log();
        pulse_start();
        chk("t2_busy", 64'(busy), 64'd1);
        s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        send("t2", 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2_nwrites", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk("t2_addr0", 64'(wr_addr[0]), 64'h000);
            chk("t2_data0", 64'(wr_data[0]), 64'hDEADBEEF);
            chk("t2_addr1", 64'(wr_addr[1]), 64'h001);
            chk("t2_data1", 64'(wr_data[1]), 64'h00000001);
            chk("t2_wr_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd5);
`ifndef LOADER_CHECKSUM_EN
            chk("t2_done_lat", 64'(done_cyc), 64'(wr_cyc[1] + 1));
`endif
        end
        chk("t2_done_after_last", 64'(done_cyc), 64'(last_acc + 1 + (`ifdef LOADER_CHECKSUM_EN 0 `else 1 `endif)));
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_hold", 64'(cpu_hold), 64'd0);
        chk("t2_busy_end", 64'(busy), 64'd0);

        // Same stream with randomly gapped valid, restarted from DONE
        clear_log();
        pulse_start();
        chk("t3_done_cleared", 64'(done), 64'd0);
        chk("t3_hold", 64'(cpu_hold), 64'd1);
        s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        send("t3", 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t3_nwrites", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk("t3_addr0", 64'(wr_addr[0]), 64'h000);
            chk("t3_data0", 64'(wr_data[0]), 64'hDEADBEEF);
            chk("t3_addr1", 64'(wr_addr[1]), 64'h001);
            chk("t3_data1", 64'(wr_data[1]), 64'h00000001);
        end
        chk("t3_ready_in_write", 64'(ready_in_write), 64'd0);
        chk("t3_done", 64'(done), 64'd1);

        // Zero-length image
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h00};
        send("t4", 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t4_nwrites", 64'(wr_addr.size()), 64'd0);
        chk("t4_done_lat", 64'(done_cyc), 64'(last_acc + 1));
        chk("t4_done", 64'(done), 64'd1);

        // Oversized count, then recovery from ERROR
        clear_log();
        pulse_start();
        s = '{8'h10, 8'h01};
        send("t5", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_error", 64'(error), 64'd1);
        chk("t5_hold", 64'(cpu_hold), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ready", 64'(byte_ready), 64'd0);
        chk("t5_nwrites", 64'(wr_addr.size()), 64'd0);
        pulse_start();
        chk("t5_error_cleared", 64'(error), 64'd0);
        s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send("t5b", 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5b_done", 64'(done), 64'd1);
        chk("t5b_nwrites", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) chk("t5b_data0", 64'(wr_data[0]), 64'h11223344);

        // Reset in the middle of a load, then reload from address 0
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send("t1", 1'b0, 1'b0);
        chk("t1_partial_write", 64'(wr_addr.size()), 64'd1);
        do_reset();
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        send("t1b", 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t1b_nwrites", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            chk("t1b_addr0", 64'(wr_addr[0]), 64'h000);
            chk("t1b_data0", 64'(wr_data[0]), 64'hCAFEBABE);
        end
        chk("t1b_done", 64'(done), 64'd1);
        chk("t1b_hold", 64'(cpu_hold), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // XOR of 00 01 12 34 56 78 is 09
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send("t6", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_error", 64'(error), 64'd0);
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        send("t6b", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6b_error", 64'(error), 64'd1);
        chk("t6b_hold", 64'(cpu_hold), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
